// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t   : FSM encoding (ST_IDLE, ST_RUN)
//   cnt_width : iteration counter width derived from the dividend width
package div_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Counter runs 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (combinational).
//   r        in   D_WIDTH  partial remainder before the step
//   n_bit    in   1        next dividend bit shifted in at the LSB
//   divisor  in   D_WIDTH  divisor
//   r_next   out  D_WIDTH  partial remainder after the step
//   q_bit    out  1        quotient bit produced by the step
// The shifted value is D_WIDTH+1 bits wide, but only the compare needs its
// MSB: after a taken subtract the result fits in D_WIDTH bits, and for a
// zero divisor only the low bits are ever used again, so the subtraction is
// done modulo 2^D_WIDTH.
module div_step #(
   parameter int D_WIDTH = 32
) (
   input  logic [D_WIDTH-1:0] r,
   input  logic               n_bit,
   input  logic [D_WIDTH-1:0] divisor,
   output logic [D_WIDTH-1:0] r_next,
   output logic               q_bit
);

   logic [D_WIDTH:0] t;

   assign t      = {r, n_bit};
   assign q_bit  = (t >= {1'b0, divisor});
   assign r_next = q_bit ? (t[D_WIDTH-1:0] - divisor) : t[D_WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle,
// constant latency of N_WIDTH cycles from the accept edge to done.
//   clk, rst_n   clock, synchronous active-low reset
//   start        request, sampled only while idle
//   dividend     N_WIDTH operand, captured on accept
//   divisor      D_WIDTH operand, captured on accept
//   busy         operation in progress
//   done         one-cycle pulse when quotient/remainder update
//   quotient     N_WIDTH result, held until the next done
//   remainder    D_WIDTH result, held until the next done
//   div_by_zero  divisor of the presented result was zero
module seq_divider
   import div_pkg::*;
#(
   parameter int N_WIDTH = 64,
   parameter int D_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [N_WIDTH-1:0] dividend,
   input  logic [D_WIDTH-1:0] divisor,
   output logic               busy,
   output logic               done,
   output logic [N_WIDTH-1:0] quotient,
   output logic [D_WIDTH-1:0] remainder,
   output logic               div_by_zero
);

   localparam int CNT_W = cnt_width(N_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WIDTH - 1);

   state_t             state, state_nxt;
   logic               accept, last;
   logic [CNT_W-1:0]   cnt;
   // Dividend and quotient share one shift register: each step consumes the
   // MSB and shifts the new quotient bit in at the LSB.
   logic [N_WIDTH-1:0] sreg;
   logic [N_WIDTH-1:0] sreg_nxt;
   logic [D_WIDTH-1:0] dvsr;
   logic [D_WIDTH-1:0] r, r_nxt;
   logic               q_bit;
   logic               dz_pend;

   div_step #(.D_WIDTH(D_WIDTH)) u_step (
      .r       (r),
      .n_bit   (sreg[N_WIDTH-1]),
      .divisor (dvsr),
      .r_next  (r_nxt),
      .q_bit   (q_bit)
   );

   assign sreg_nxt = {sreg[N_WIDTH-2:0], q_bit};
   assign busy     = (state == ST_RUN);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt == CNT_LAST) begin
               last      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt         <= '0;
         sreg        <= '0;
         dvsr        <= '0;
         r           <= '0;
         dz_pend     <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= last;
         if (accept) begin
            sreg    <= dividend;
            dvsr    <= divisor;
            dz_pend <= (divisor == '0);
            r       <= '0;
            cnt     <= '0;
         end else if (state == ST_RUN) begin
            sreg <= sreg_nxt;
            r    <= r_nxt;
            cnt  <= cnt + 1'b1;
            // Outputs move only here, so they stay stable while busy.
            if (last) begin
               quotient    <= sreg_nxt;
               remainder   <= r_nxt;
               div_by_zero <= dz_pend;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// compared against plain integer division.
module tb_seq_divider;

   localparam int N = 64;
   localparam int D = 32;
   localparam int TMO = N + 20;

   logic         clk = 1'b0;
   logic         rst_n, start, busy, done, div_by_zero;
   logic [N-1:0] dividend, quotient;
   logic [D-1:0] divisor, remainder;

   int n_chk = 0;
   int n_err = 0;

   seq_divider #(.N_WIDTH(N), .D_WIDTH(D)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [N-1:0] a, input logic [D-1:0] b,
                                 output logic [N-1:0] q, output logic [D-1:0] r);
      if (b == 0) begin
         q = '1;
         r = a[D-1:0];
      end else begin
         q = a / {{(N-D){1'b0}}, b};
         r = D'(a % {{(N-D){1'b0}}, b});
      end
   endfunction

   // Called one negedge after the accept edge. Counts edges until done and
   // flags any output movement or done pulse before the finish. Operands are
   // scrambled at cycle chg_at (start still high) to prove they are ignored.
   task automatic wait_done(input int chg_at, output int lat, output bit moved);
      logic [N-1:0] q0;
      logic [D-1:0] r0;
      logic         z0;
      q0 = quotient; r0 = remainder; z0 = div_by_zero;
      lat = 0; moved = 1'b0;
      while (!done && lat < TMO) begin
         if (lat == chg_at) begin
            dividend = {$urandom, $urandom};
            divisor  = $urandom;
         end
         @(negedge clk);
         lat++;
         if (!done && (quotient !== q0 || remainder !== r0 || div_by_zero !== z0 || !busy))
            moved = 1'b1;
      end
   endtask

   task automatic check_res(input string tag, input logic [N-1:0] a, input logic [D-1:0] b,
                            input int lat, input bit moved);
      logic [N-1:0] q;
      logic [D-1:0] r;
      model(a, b, q, r);
      chk({tag, ".lat"}, 64'(lat), 64'(N));
      chk({tag, ".q"}, quotient, q);
      chk({tag, ".r"}, 64'(remainder), 64'(r));
      chk({tag, ".dz"}, 64'(div_by_zero), 64'(b == 0));
      chk({tag, ".hold"}, 64'(moved), 64'd0);
      if (b != 0) begin
         chk({tag, ".ident"}, quotient * {{(N-D){1'b0}}, divisor_of(b)} + 64'(remainder), a);
         chk({tag, ".rlt"}, 64'(remainder < b), 64'd1);
      end
   endtask

   function automatic logic [D-1:0] divisor_of(input logic [D-1:0] b);
      return b;
   endfunction

   // Full single operation from a negedge; ends one cycle after done.
   task automatic op(input string tag, input logic [N-1:0] a, input logic [D-1:0] b);
      int lat;
      bit moved;
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0;
      wait_done(-1, lat, moved);
      check_res(tag, a, b, lat, moved);
      @(negedge clk);
      chk({tag, ".pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int lat;
      bit moved, seen;
      logic [N-1:0] a;
      logic [D-1:0] b;

      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.done", 64'(done), 64'd0);
      chk("rst.q", quotient, 64'd0);
      chk("rst.r", 64'(remainder), 64'd0);
      chk("rst.dz", 64'(div_by_zero), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      op("basic", 64'd100, 32'd7);
      op("max", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
      chk("max.qconst", quotient, 64'h0000_0001_0000_0001);
      op("dz", 64'h1234_5678_9ABC_DEF0, 32'd0);
      chk("dz.rconst", 64'(remainder), 64'h9ABC_DEF0);

      // Back-to-back with start held high; operands scrambled mid-op A.
      start = 1'b1; dividend = 64'd1000; divisor = 32'd3;
      @(negedge clk);
      wait_done(10, lat, moved);
      check_res("b2bA", 64'd1000, 32'd3, lat, moved);
      chk("b2bA.q", quotient, 64'd333);
      dividend = 64'h1_0000_0000; divisor = 32'd65537;
      @(negedge clk);
      chk("b2bB.nobubble", 64'(busy), 64'd1);
      chk("b2bB.pulse", 64'(done), 64'd0);
      start = 1'b0;
      wait_done(-1, lat, moved);
      check_res("b2bB", 64'h1_0000_0000, 32'd65537, lat, moved);
      chk("b2bB.q", quotient, 64'd65535);
      @(negedge clk);

      // Reset in the middle of an operation.
      start = 1'b1; dividend = 64'd1000; divisor = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst.busy", 64'(busy), 64'd0);
      chk("mrst.done", 64'(done), 64'd0);
      chk("mrst.q", quotient, 64'd0);
      chk("mrst.r", 64'(remainder), 64'd0);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (N + 5) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      chk("mrst.nodone", 64'(seen), 64'd0);
      op("post_rst", 64'd50, 32'd5);
      chk("post_rst.q", quotient, 64'd10);

      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 5))
            0: begin a = {$urandom, $urandom}; b = 32'd1; end
            1: begin a = {$urandom, $urandom}; b = 32'd0; end
            2: begin a = 64'($urandom_range(0, 1000)); b = $urandom_range(1001, 32'hFFFF_FFFF); end
            3: begin a = 64'($urandom); b = $urandom_range(1, 255); end
            default: begin a = {$urandom, $urandom}; b = $urandom; end
         endcase
         op("rnd", a, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
